// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
//   arb_state_e : sequencer states (idle, memory access, read wait, response)
//   ARB_RR/ARB_FIXED : arbitration policy selectors for ARB_MODE
//   P_CPU/P_DBG : port indices (0 = CPU load/store unit, 1 = debug/DMA loader)
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StWait,
      StResp
   } arb_state_e;

   localparam int unsigned ARB_RR    = 0;
   localparam int unsigned ARB_FIXED = 1;

   localparam logic P_CPU = 1'b0;
   localparam logic P_DBG = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner select between the two requesters.
//   req0, req1   : pending requests
//   last_grant   : port granted most recently (round-robin history)
//   grant_valid  : at least one request pending
//   grant_sel    : winning port index
module dmem_arb_pick
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ARB_MODE = ARB_RR
) (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_sel
);

   always_comb begin
      grant_valid = req0 | req1;
      grant_sel   = P_CPU;
      if (req0 && req1) begin
         // On a tie, round-robin hands the grant to the port that did not win last.
         grant_sel = (ARB_MODE == ARB_FIXED) ? P_CPU : ~last_grant;
      end else if (req1) begin
         grant_sel = P_DBG;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between two requesters.
// One access at a time is latched in IDLE, driven onto the memory port for one
// cycle, optionally waits out the memory read latency, then acks for one cycle.
//   sysclk, reset_n          : clock, asynchronous active-low reset
//   req/we/addr/wdata 0/1    : requester side inputs (req held until ack)
//   ack0/ack1                : one-cycle completion pulse
//   rdata0/rdata1            : read data, held until that port's next read
//   busy                     : high while not idle
//   mem_addr/mem_wdata/mem_write/mem_rdata : memory port
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned RD_LAT   = 0,
   parameter int unsigned ARB_MODE = ARB_RR
) (
   input  logic              sysclk,
   input  logic              reset_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);

   // Counter starts at RD_LAT-1 because the ACCESS cycle already covers one cycle of latency.
   localparam logic [1:0] WaitInit = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

   arb_state_e state;
   logic       sel;
   logic       last_grant;
   logic [1:0] wait_cnt;
   logic       grant_valid;
   logic       grant_sel;

   dmem_arb_pick #(
      .ARB_MODE (ARB_MODE)
   ) u_pick (
      .req0        (req0),
      .req1        (req1),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_sel   (grant_sel)
   );

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= StIdle;
         sel        <= P_CPU;
         last_grant <= P_DBG;
         wait_cnt   <= 2'd0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_write  <= 1'b0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
         busy       <= 1'b0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         unique case (state)
            StIdle: begin
               if (grant_valid) begin
                  sel        <= grant_sel;
                  last_grant <= grant_sel;
                  mem_addr   <= (grant_sel == P_DBG) ? addr1 : addr0;
                  mem_wdata  <= (grant_sel == P_DBG) ? wdata1 : wdata0;
                  mem_write  <= (grant_sel == P_DBG) ? we1 : we0;
                  busy       <= 1'b1;
                  state      <= StAccess;
               end
            end
            StAccess: begin
               // mem_write doubles as the latched write flag for this access.
               mem_write <= 1'b0;
               if (mem_write || (RD_LAT == 0)) begin
                  if (!mem_write) begin
                     if (sel == P_DBG) rdata1 <= mem_rdata;
                     else              rdata0 <= mem_rdata;
                  end
                  if (sel == P_DBG) ack1 <= 1'b1;
                  else              ack0 <= 1'b1;
                  state <= StResp;
               end else begin
                  wait_cnt <= WaitInit;
                  state    <= StWait;
               end
            end
            StWait: begin
               if (wait_cnt == 2'd0) begin
                  if (sel == P_DBG) begin
                     rdata1 <= mem_rdata;
                     ack1   <= 1'b1;
                  end else begin
                     rdata0 <= mem_rdata;
                     ack0   <= 1'b1;
                  end
                  state <= StResp;
               end else begin
                  wait_cnt <= wait_cnt - 2'd1;
               end
            end
            StResp: begin
               // No arbitration here: a held req is only seen again in the following IDLE.
               busy  <= 1'b0;
               state <= StIdle;
            end
            default: begin
               busy  <= 1'b0;
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter.
// Instance a: RD_LAT = 0, round-robin, combinational memory model.
// Instance b: RD_LAT = 2, fixed priority, two-stage registered memory model.
module tb_dmem_arbiter;

   logic clk;
   logic a_rst_n, b_rst_n;

   logic       a_req0, a_req1, a_we0, a_we1;
   logic [7:0] a_addr0, a_addr1, a_wdata0, a_wdata1;
   logic       a_ack0, a_ack1, a_busy, a_mem_write;
   logic [7:0] a_rdata0, a_rdata1, a_mem_addr, a_mem_wdata, a_mem_rdata;

   logic       b_req0, b_req1, b_we0, b_we1;
   logic [7:0] b_addr0, b_addr1, b_wdata0, b_wdata1;
   logic       b_ack0, b_ack1, b_busy, b_mem_write;
   logic [7:0] b_rdata0, b_rdata1, b_mem_addr, b_mem_wdata, b_mem_rdata;

   logic [7:0] mem_a [256];
   logic [7:0] mem_b [256];
   logic [7:0] b_r1, b_r2;

   typedef struct {
      bit         port;
      bit         rd;
      logic [7:0] data;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   int tests  = 0;
   int failed = 0;

   dmem_arbiter #(
      .ADDR_W   (8),
      .DATA_W   (8),
      .RD_LAT   (0),
      .ARB_MODE (0)
   ) u_a (
      .sysclk    (clk),
      .reset_n   (a_rst_n),
      .req0      (a_req0),
      .req1      (a_req1),
      .we0       (a_we0),
      .we1       (a_we1),
      .addr0     (a_addr0),
      .addr1     (a_addr1),
      .wdata0    (a_wdata0),
      .wdata1    (a_wdata1),
      .ack0      (a_ack0),
      .ack1      (a_ack1),
      .rdata0    (a_rdata0),
      .rdata1    (a_rdata1),
      .busy      (a_busy),
      .mem_addr  (a_mem_addr),
      .mem_wdata (a_mem_wdata),
      .mem_write (a_mem_write),
      .mem_rdata (a_mem_rdata)
   );

   dmem_arbiter #(
      .ADDR_W   (8),
      .DATA_W   (8),
      .RD_LAT   (2),
      .ARB_MODE (1)
   ) u_b (
      .sysclk    (clk),
      .reset_n   (b_rst_n),
      .req0      (b_req0),
      .req1      (b_req1),
      .we0       (b_we0),
      .we1       (b_we1),
      .addr0     (b_addr0),
      .addr1     (b_addr1),
      .wdata0    (b_wdata0),
      .wdata1    (b_wdata1),
      .ack0      (b_ack0),
      .ack1      (b_ack1),
      .rdata0    (b_rdata0),
      .rdata1    (b_rdata1),
      .busy      (b_busy),
      .mem_addr  (b_mem_addr),
      .mem_wdata (b_mem_wdata),
      .mem_write (b_mem_write),
      .mem_rdata (b_mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory models
   assign a_mem_rdata = mem_a[a_mem_addr];
   always @(posedge clk) if (a_mem_write) mem_a[a_mem_addr] <= a_mem_wdata;

   assign b_mem_rdata = b_r2;
   always @(posedge clk) begin
      if (b_mem_write) mem_b[b_mem_addr] <= b_mem_wdata;
      b_r1 <= mem_b[b_mem_addr];
      b_r2 <= b_r1;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      tests++;
      failed++;
      $display("FAIL %s: timed out waiting for ack", nm);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input bit dut, input bit port, input bit rd, input logic [7:0] data);
      exp_t e;
      e.port = port;
      e.rd   = rd;
      e.data = data;
      if (dut) qb.push_back(e);
      else     qa.push_back(e);
   endtask

   task automatic drive(input bit dut, input bit port, input bit req, input bit we,
                        input logic [7:0] addr, input logic [7:0] wdata);
      case ({dut, port})
         2'b00: begin a_req0 = req; a_we0 = we; a_addr0 = addr; a_wdata0 = wdata; end
         2'b01: begin a_req1 = req; a_we1 = we; a_addr1 = addr; a_wdata1 = wdata; end
         2'b10: begin b_req0 = req; b_we0 = we; b_addr0 = addr; b_wdata0 = wdata; end
         default: begin b_req1 = req; b_we1 = we; b_addr1 = addr; b_wdata1 = wdata; end
      endcase
   endtask

   function automatic logic get_ack(input bit dut, input bit port);
      if (dut) return port ? b_ack1 : b_ack0;
      return port ? a_ack1 : a_ack0;
   endfunction

   function automatic logic get_busy(input bit dut);
      return dut ? b_busy : a_busy;
   endfunction

   function automatic logic [35:0] outs(input bit dut);
      if (dut) return {b_ack0, b_ack1, b_busy, b_mem_write, b_mem_addr, b_mem_wdata,
                       b_rdata0, b_rdata1};
      return {a_ack0, a_ack1, a_busy, a_mem_write, a_mem_addr, a_mem_wdata, a_rdata0, a_rdata1};
   endfunction

   // One complete access: checks busy each cycle, ack latency, and return to idle.
   task automatic access(input bit dut, input bit port, input bit we, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] exp_rd, input int lat,
                         input string nm);
      int n;
      bit got;
      n   = 0;
      got = 1'b0;
      drive(dut, port, 1'b1, we, addr, wdata);
      push(dut, port, !we, exp_rd);
      while (!got && n < 20) begin
         tick();
         n++;
         chk({nm, "_busy"}, get_busy(dut), 1'b1);
         if (get_ack(dut, port)) got = 1'b1;
      end
      drive(dut, port, 1'b0, 1'b0, 8'h00, 8'h00);
      if (!got) fail(nm);
      else      chk({nm, "_lat"}, n, lat);
      tick();
      chk({nm, "_idle"}, get_busy(dut), 1'b0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (a_ack0 && a_ack1) begin
         tests++; failed++;
         $display("FAIL a_ack_overlap: got both acks, expected at most one");
      end
      if (b_ack0 && b_ack1) begin
         tests++; failed++;
         $display("FAIL b_ack_overlap: got both acks, expected at most one");
      end
      if (a_ack0 || a_ack1) begin
         if (qa.size() == 0) begin
            tests++; failed++;
            $display("FAIL a_unexpected_ack: got ack on port %0d, expected none", a_ack1);
         end else begin
            e = qa.pop_front();
            chk("a_ack_port", a_ack1, e.port);
            if (e.rd) chk("a_rdata", e.port ? a_rdata1 : a_rdata0, e.data);
         end
      end
      if (b_ack0 || b_ack1) begin
         if (qb.size() == 0) begin
            tests++; failed++;
            $display("FAIL b_unexpected_ack: got ack on port %0d, expected none", b_ack1);
         end else begin
            e = qb.pop_front();
            chk("b_ack_port", b_ack1, e.port);
            if (e.rd) chk("b_rdata", e.port ? b_rdata1 : b_rdata0, e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n, cnt0, n3, n1;
      bit  done0, done1, gap;

      a_rst_n = 1'b0;
      b_rst_n = 1'b0;
      drive(0, 0, 0, 0, 8'h00, 8'h00);
      drive(0, 1, 0, 0, 8'h00, 8'h00);
      drive(1, 0, 0, 0, 8'h00, 8'h00);
      drive(1, 1, 0, 0, 8'h00, 8'h00);
      tick();
      tick();
      chk("a_reset_outs", outs(0), 36'h0);
      chk("b_reset_outs", outs(1), 36'h0);
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;
      tick();

      // Port 0 write 0x10 <= 0x55, cycle by cycle
      drive(0, 0, 1, 1, 8'h10, 8'h55);
      push(0, 0, 0, 8'h00);
      tick();
      chk("wr_mem_write", a_mem_write, 1'b1);
      chk("wr_mem_addr", a_mem_addr, 8'h10);
      chk("wr_mem_wdata", a_mem_wdata, 8'h55);
      chk("wr_no_early_ack", a_ack0, 1'b0);
      tick();
      chk("wr_ack_at_2", a_ack0, 1'b1);
      chk("wr_mem_write_one_cycle", a_mem_write, 1'b0);
      drive(0, 0, 0, 0, 8'h00, 8'h00);
      tick();
      chk("wr_idle", a_busy, 1'b0);
      chk("wr_mem_content", mem_a[8'h10], 8'h55);

      access(0, 0, 0, 8'h10, 8'h00, 8'h55, 2, "rd0");

      // Preload for round-robin; last access on port 1 so port 0 wins the first tie
      access(0, 0, 1, 8'h01, 8'h11, 8'h00, 2, "pre01");
      access(0, 1, 1, 8'h02, 8'h22, 8'h00, 2, "pre02");

      // Round-robin: both requests rise together three times
      for (int r = 0; r < 3; r++) begin
         push(0, 0, 1, 8'h11);
         push(0, 1, 1, 8'h22);
         drive(0, 0, 1, 0, 8'h01, 8'h00);
         drive(0, 1, 1, 0, 8'h02, 8'h00);
         n = 0; done0 = 0; done1 = 0; gap = 0;
         while (!(done0 && done1) && n < 30) begin
            tick();
            n++;
            if (gap) begin
               chk("rr_gap_idle", a_busy, 1'b0);
               gap = 0;
            end
            if (a_ack0) begin drive(0, 0, 0, 0, 8'h00, 8'h00); done0 = 1; gap = 1; end
            if (a_ack1) begin drive(0, 1, 0, 0, 8'h00, 8'h00); done1 = 1; gap = 1; end
         end
         if (!(done0 && done1)) fail("rr_round");
         tick();
         if (gap) chk("rr_gap_idle", a_busy, 1'b0);
      end

      // Early req drop with changed addr/data mid-access
      drive(0, 0, 1, 1, 8'h20, 8'h3C);
      push(0, 0, 0, 8'h00);
      tick();
      drive(0, 0, 0, 0, 8'h21, 8'hFF);
      n = 0; done0 = 0;
      while (!done0 && n < 10) begin
         tick();
         n++;
         if (a_ack0) done0 = 1;
      end
      if (!done0) fail("drop_ack");
      else        chk("drop_ack_lat", n, 1);
      tick();
      chk("drop_mem_content", mem_a[8'h20], 8'h3C);

      // Instance b: write then RD_LAT=2 read on port 1
      access(1, 1, 1, 8'h03, 8'hA7, 8'h00, 2, "b_wr03");
      access(1, 1, 0, 8'h03, 8'h00, 8'hA7, 4, "b_rd03");
      chk("b_rdata1_held", b_rdata1, 8'hA7);

      // Fixed priority: req0 held through three accesses, req1 waiting
      for (int i = 0; i < 3; i++) push(1, 0, 0, 8'h00);
      push(1, 1, 1, 8'hA7);
      drive(1, 0, 1, 1, 8'h40, 8'h5A);
      drive(1, 1, 1, 0, 8'h03, 8'h00);
      n = 0; cnt0 = 0; n3 = 0; n1 = 0; done1 = 0;
      while (!done1 && n < 60) begin
         tick();
         n++;
         if (b_ack0) begin
            cnt0++;
            if (cnt0 == 3) begin
               drive(1, 0, 0, 0, 8'h00, 8'h00);
               n3 = n;
            end
         end
         if (b_ack1) begin
            drive(1, 1, 0, 0, 8'h00, 8'h00);
            done1 = 1;
            n1 = n;
         end
      end
      if (!done1) fail("fix_port1");
      chk("fix_port0_count", cnt0, 3);
      chk("fix_port1_next", n1 - n3, 5);
      chk("fix_mem_content", mem_b[8'h40], 8'h5A);
      tick();

      // Reset during the WAIT of a port 0 read
      drive(1, 0, 1, 0, 8'h03, 8'h00);
      tick();
      tick();
      chk("rst_in_wait_busy", b_busy, 1'b1);
      b_rst_n = 1'b0;
      #1;
      chk("rst_mid_outs", outs(1), 36'h0);
      drive(1, 0, 0, 0, 8'h00, 8'h00);
      tick();
      tick();
      b_rst_n = 1'b1;
      repeat (6) tick();
      chk("rst_no_ack_outs", outs(1), 36'h0);
      access(1, 0, 0, 8'h03, 8'h00, 8'hA7, 4, "post_rst_rd");

      repeat (3) tick();
      chk("qa_drained", qa.size(), 0);
      chk("qb_drained", qb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 8-bit data memory between two requesters: port 0 (CPU load/store unit) and port 1 (debug/DMA loader).
- Arbitrates, sequences one access at a time onto the memory port, waits out the memory read latency, and returns data with a one-cycle ack pulse.
- Sits between the requesters and the dataMemory instance in the top level.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- RD_LAT, 0, memory read latency in cycles; legal values 0..3.
- ARB_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority with port 0 highest.

Ports:
- sysclk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request; held high until the matching ack.
- we0 / we1  in  1  1 = write, 0 = read; stable while req is high.
- addr0 / addr1  in  ADDR_W  access address.
- wdata0 / wdata1  in  DATA_W  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  DATA_W  read data; valid in the ack cycle and held until that port's next read completes.
- busy  out  1  high whenever state is not IDLE.
- mem_addr  out  ADDR_W  to memory addr.
- mem_wdata  out  DATA_W  to memory writeData.
- mem_write  out  1  to memory write.
- mem_rdata  in  DATA_W  from memory readData.

Behaviour:
- Reset (async assert, sync deassert at the next edge):
  - state = IDLE; mem_addr = 0, mem_wdata = 0, mem_write = 0.
  - ack0 = ack1 = 0; rdata0 = rdata1 = 0; busy = 0.
  - last_grant = 1, so port 0 wins the first tie.
  - An access in flight is abandoned with no ack. A write already clocked into memory stays written.
- FSM states: IDLE, ACCESS, WAIT, RESP. All outputs are registered.
- IDLE:
  - No req: remain in IDLE.
  - Any req: pick a winner, set sel, register mem_addr and mem_wdata from the winner, set mem_write = winner's we, go to ACCESS.
- Winner selection:
  - Single request: that port wins.
  - Both requests: ARB_MODE = 0 grants the port not equal to last_grant; ARB_MODE = 1 grants port 0.
  - last_grant updates on every grant.
- ACCESS (exactly 1 cycle):
  - mem_write is high for this cycle only on writes; it drops to 0 on leaving ACCESS.
  - Write, or read with RD_LAT = 0: capture mem_rdata into rdata[sel] (reads only), go to RESP.
  - Read with RD_LAT > 0: load wait counter with RD_LAT-1, go to WAIT.
- WAIT:
  - Counter decrements each cycle; mem_addr is held.
  - At counter == 0: capture mem_rdata into rdata[sel], go to RESP.
- RESP (1 cycle):
  - ack[sel] = 1 and no arbitration; next state is IDLE.
  - A requester still holding req in the RESP cycle is not re-served from that cycle. Continued req in the following IDLE cycle is a new request.
- Latency from a req sampled in IDLE to ack: 2 cycles for writes, 2 + RD_LAT cycles for reads.
- Throughput: one access per 3 (+RD_LAT for reads) cycles.
- The losing requester keeps req high and is served next.
  - Round-robin mode guarantees it is next.
  - Fixed mode can starve port 1 under continuous port 0 traffic; this is accepted.
- Protocol violations: a req dropped mid-access still completes and acks. Addr/we/wdata changes mid-access are ignored, because values are latched in IDLE.
- Never both acks in one cycle. mem_write is never high outside ACCESS.
- No address range check; addresses wrap naturally within ADDR_W.

Decomposition:
- Package dmem_arb_pkg:
  - state enum (IDLE, ACCESS, WAIT, RESP).
  - ARB_RR = 0, ARB_FIXED = 1.
  - Port index constants P_CPU = 0, P_DBG = 1.
- Sub-module dmem_arb_pick: combinational winner select from req0, req1, last_grant and ARB_MODE. Outputs grant_valid and grant_sel.
- The FSM, wait counter and data registers stay in dmem_arbiter.

Test Plan:
- Reset mid-access: assert reset_n = 0 during the WAIT of a read -> ack0 never pulses; all outputs 0; busy = 0; next access from port 0 works normally.
- Single write, then read, on port 0 (RD_LAT = 0): write addr 0x10 data 0x55 -> mem_write high exactly 1 cycle with mem_addr = 0x10, ack0 two cycles after req; then read 0x10 -> rdata0 = 0x55 with ack0.
- Read latency (RD_LAT = 2): port 1 reads 0x03 preloaded with 0xA7 -> ack1 exactly 4 cycles after req is sampled, rdata1 = 0xA7, busy high for 4 cycles.
- Simultaneous requests, round-robin: req0 and req1 rise together three times (addresses 0x01 and 0x02) -> grant order 0, 1, 0, 1, 0, 1; acks never overlap; a gap of at least one IDLE cycle between accesses.
- Fixed priority (ARB_MODE = 1): req0 held continuously with req1 high -> port 0 served on every access and ack1 never asserts; drop req0 -> port 1 served on the next IDLE.
- Early req drop: port 0 drops req0 in the ACCESS cycle of a write to 0x20 with data 0x3C -> write completes, ack0 still pulses, memory[0x20] = 0x3C.
